// File: rtl/xbar_pkg.sv
// Shared types and constants for the crossbar ingress path: frame geometry,
// lane-select width and the byte/frame helpers used by the serializer.
package xbar_pkg;

  localparam int PORTS     = 8;
  localparam int DATA_W    = 32;
  localparam int FRAME_LEN = 10;
  localparam int BYTES     = DATA_W / 8;

  localparam int SEL_W = $clog2(PORTS);
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam int IDX_W = $clog2(BYTES);

  typedef logic [SEL_W-1:0]     port_sel_t;
  typedef logic [FRAME_LEN-1:0] frame_t;
  typedef logic [CNT_W-1:0]     bit_cnt_t;
  typedef logic [IDX_W-1:0]     byte_idx_t;
  typedef logic [DATA_W-1:0]    word_t;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_e;

  localparam bit_cnt_t  LAST_BIT  = bit_cnt_t'(FRAME_LEN - 1);
  localparam bit_cnt_t  PRE_LAST  = bit_cnt_t'(FRAME_LEN - 2);
  localparam byte_idx_t LAST_BYTE = byte_idx_t'(BYTES - 1);

  function automatic logic [7:0] byte_of(input word_t w, input byte_idx_t idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

  // Start bit in bit 0 so the frame shifts out LSB-first.
  function automatic frame_t make_frame(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

endpackage

// File: rtl/xbar_if.sv
// Crossbar ingress bus: frame strobe, destination select and data word in,
// serial lanes and status pulses out.
interface xbar_if (
  input logic clk,
  input logic rst
);
  import xbar_pkg::*;

  logic              clk10;
  port_sel_t         mux_sel;
  word_t             A;
  logic [PORTS-1:0]  ser_out;
  logic              busy;
  logic              word_done;
  logic              frame_err;

  modport master (
    input  clk, rst, ser_out, busy, word_done, frame_err,
    output clk10, mux_sel, A
  );

  modport slave (
    input  clk, rst, clk10, mux_sel, A,
    output ser_out, busy, word_done, frame_err
  );

endinterface

// File: rtl/frame_serializer.sv
// One-frame shifter: loads start/data/stop, shifts one bit per clock and
// parks on the stop bit until the next load.
module frame_serializer
  import xbar_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     load_i,
  input  logic [7:0] byte_i,
  output logic     bit_next_o,
  output bit_cnt_t bit_cnt_o,
  output logic     done_o
);

  frame_t   frame_q, frame_d;
  bit_cnt_t bit_cnt_q, bit_cnt_d;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    if (load_i) begin
      frame_d   = make_frame(byte_i);
      bit_cnt_d = '0;
    end else if (bit_cnt_q != LAST_BIT) begin
      frame_d   = {1'b1, frame_q[FRAME_LEN-1:1]};
      bit_cnt_d = bit_cnt_q + bit_cnt_t'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_q   <= '1;
      bit_cnt_q <= '0;
    end else begin
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // The lane register in the wrapper captures the bit that will be current
  // after this edge, so the line and the counter stay aligned.
  assign bit_next_o = frame_d[0];
  assign bit_cnt_o  = bit_cnt_q;
  assign done_o     = (bit_cnt_q == LAST_BIT);

endmodule

// File: rtl/input_block.sv
// Crossbar ingress stage: captures a word and destination on a frame strobe,
// then sends it byte by byte as 10-bit frames on the selected serial lane.
module input_block
  import xbar_pkg::*;
(
  xbar_if.slave port
);

  logic clk;
  logic rst;
  assign clk = port.clk;
  assign rst = port.rst;

  state_e           state_q, state_d;
  word_t            hold_q, hold_d;
  port_sel_t        dest_q, dest_d;
  byte_idx_t        byte_idx_q, byte_idx_d;
  logic [PORTS-1:0] ser_out_q, ser_out_d;
  logic             word_done_q, word_done_d;
  logic             frame_err_q, frame_err_d;

  logic       busy;
  logic       frame_done;
  logic       load;
  logic       next_byte;
  logic       bit_next;
  bit_cnt_t   bit_cnt;
  logic [7:0] ser_byte;

  assign busy      = (state_q == ST_SEND);
  assign load      = port.clk10 && (!busy || (byte_idx_q == LAST_BYTE && frame_done));
  assign next_byte = port.clk10 && busy && frame_done && (byte_idx_q != LAST_BYTE);
  assign ser_byte  = load ? byte_of(port.A, '0)
                          : byte_of(hold_q, byte_idx_q + byte_idx_t'(1));

  frame_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load || next_byte),
    .byte_i    (ser_byte),
    .bit_next_o(bit_next),
    .bit_cnt_o (bit_cnt),
    .done_o    (frame_done)
  );

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    dest_d     = dest_q;
    byte_idx_d = byte_idx_q;
    if (load) begin
      state_d    = ST_SEND;
      hold_d     = port.A;
      dest_d     = port.mux_sel;
      byte_idx_d = '0;
    end else if (next_byte) begin
      byte_idx_d = byte_idx_q + byte_idx_t'(1);
    end else if (busy && frame_done && byte_idx_q == LAST_BYTE) begin
      state_d = ST_IDLE;
    end

    // Byte 3 at bit 8 can only advance to its stop bit, which lasts one cycle.
    word_done_d = busy && (byte_idx_q == LAST_BYTE) && (bit_cnt == PRE_LAST);
    frame_err_d = port.clk10 && busy && !frame_done;

    ser_out_d = '1;
    if (state_d == ST_SEND) ser_out_d[dest_d] = bit_next;
  end

  // NOTE: hold_q is plain datapath and would not strictly need a reset, but
  // clearing it keeps post-reset state fully defined and cheap at this size.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      dest_q      <= '0;
      byte_idx_q  <= '0;
      ser_out_q   <= '1;
      word_done_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      dest_q      <= dest_d;
      byte_idx_q  <= byte_idx_d;
      ser_out_q   <= ser_out_d;
      word_done_q <= word_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign port.ser_out   = ser_out_q;
  assign port.busy      = busy;
  assign port.word_done = word_done_q;
  assign port.frame_err = frame_err_q;

endmodule

// File: tb/tb_input_block.sv
// Directed bench for input_block: table of words with expected bytes and
// per-word corner options, plus hand-written reset sequences.
module tb_input_block;
  import xbar_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  xbar_if bus (.clk(clk), .rst(rst));
  input_block dut (.port(bus.slave));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    word_t            a;
    port_sel_t        sel;
    logic [PORTS-1:0] onehot;
    logic [3:0][7:0]  bytes;
    bit               scramble;
    int               gap_byte;
    int               gap_len;
    int               err_byte;
    int               err_bit;
    bit               chain;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic strobe);
    bus.clk10 = strobe;
    @(posedge clk);
    #1;
    bus.clk10 = 1'b0;
  endtask

  task automatic check_idle(input string name);
    check({name, "_busy"},    {31'd0, bus.busy},      32'd0);
    check({name, "_ser_out"}, {24'd0, bus.ser_out},   32'hFF);
    check({name, "_done"},    {31'd0, bus.word_done}, 32'd0);
  endtask

  // Loads one word with a strobe and follows it through byte3's stop bit.
  task automatic send_word(input vec_t v, input int id);
    logic [39:0] bits;
    int lane_bad, wd_bad, fe_bad, busy_bad, hold_bad, frm_bad;
    logic exp_fe;
    lane_bad = 0; wd_bad = 0; fe_bad = 0; busy_bad = 0; hold_bad = 0; frm_bad = 0;
    exp_fe = 1'b0;
    bits = '0;
    bus.A       = v.a;
    bus.mux_sel = v.sel;
    step(1'b1);
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 10; k++) begin
        bits[b*10+k] = |(bus.ser_out & v.onehot);
        if ((bus.ser_out | v.onehot) !== 8'hFF)       lane_bad++;
        if (bus.word_done !== (b == 3 && k == 9))     wd_bad++;
        if (bus.frame_err !== exp_fe)                 fe_bad++;
        if (bus.busy !== 1'b1)                        busy_bad++;
        if (v.scramble) begin
          bus.mux_sel = bus.mux_sel + port_sel_t'(1);
          bus.A       = ~bus.A;
        end
        exp_fe = 1'b0;
        if (k < 9) begin
          if (b == v.err_byte && k == v.err_bit) begin
            step(1'b1);
            exp_fe = 1'b1;
          end else begin
            step(1'b0);
          end
        end else if (b < 3) begin
          if (b == v.gap_byte) begin
            for (int g = 0; g < v.gap_len; g++) begin
              step(1'b0);
              if (bus.ser_out !== 8'hFF || bus.busy !== 1'b1 ||
                  bus.word_done !== 1'b0 || bus.frame_err !== 1'b0) hold_bad++;
            end
          end
          step(1'b1);
        end
      end
    end
    for (int b = 0; b < 4; b++) begin
      check($sformatf("w%0d_byte%0d", id, b), {24'd0, bits[b*10+1 +: 8]}, {24'd0, v.bytes[b]});
      if (bits[b*10] !== 1'b0 || bits[b*10+9] !== 1'b1) frm_bad++;
    end
    check($sformatf("w%0d_framing", id),     frm_bad,  0);
    check($sformatf("w%0d_other_lanes", id), lane_bad, 0);
    check($sformatf("w%0d_word_done", id),   wd_bad,   0);
    check($sformatf("w%0d_frame_err", id),   fe_bad,   0);
    check($sformatf("w%0d_busy", id),        busy_bad, 0);
    if (v.gap_byte >= 0) check($sformatf("w%0d_gap_hold", id), hold_bad, 0);
  endtask

  initial begin
    vec_t vecs[5];
    int bad;

    vecs[0] = '{a:32'hA5C3_0F81, sel:3'd0, onehot:8'h01, bytes:{8'hA5, 8'hC3, 8'h0F, 8'h81},
                scramble:1'b0, gap_byte:-1, gap_len:0, err_byte:-1, err_bit:-1, chain:1'b0};
    vecs[1] = '{a:32'h1234_5678, sel:3'd0, onehot:8'h01, bytes:{8'h12, 8'h34, 8'h56, 8'h78},
                scramble:1'b1, gap_byte:-1, gap_len:0, err_byte:-1, err_bit:-1, chain:1'b1};
    vecs[2] = '{a:32'h3C00_FF5A, sel:3'd6, onehot:8'h40, bytes:{8'h3C, 8'h00, 8'hFF, 8'h5A},
                scramble:1'b0, gap_byte:-1, gap_len:0, err_byte:1, err_bit:4, chain:1'b0};
    vecs[3] = '{a:32'h8001_7E01, sel:3'd3, onehot:8'h08, bytes:{8'h80, 8'h01, 8'h7E, 8'h01},
                scramble:1'b0, gap_byte:1, gap_len:7, err_byte:-1, err_bit:-1, chain:1'b0};
    vecs[4] = '{a:32'h0BAD_F00D, sel:3'd5, onehot:8'h20, bytes:{8'h0B, 8'hAD, 8'hF0, 8'h0D},
                scramble:1'b0, gap_byte:-1, gap_len:0, err_byte:-1, err_bit:-1, chain:1'b0};

    bus.clk10   = 1'b0;
    bus.A       = 32'hFFFF_FFFF;
    bus.mux_sel = '0;

    // Reset held with strobes running: nothing may leave idle.
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(i % 10 == 0);
      if (bus.ser_out !== 8'hFF || bus.busy !== 1'b0 ||
          bus.word_done !== 1'b0 || bus.frame_err !== 1'b0) bad++;
    end
    check("reset_hold", bad, 0);
    check_idle("reset");

    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0);
    check_idle("post_release");

    for (int n = 0; n < 4; n++) begin
      send_word(vecs[n], n);
      if (!vecs[n].chain) begin
        step(1'b0);
        check_idle($sformatf("w%0d_end", n));
        step(1'b0);
      end
    end

    // Reset asserted at byte2 bit5 abandons the word asynchronously.
    bus.A       = 32'hCA00_BABE;
    bus.mux_sel = 3'd2;
    step(1'b1);
    for (int i = 0; i < 25; i++) step(i % 10 == 9);
    check("pre_reset_line", {24'd0, bus.ser_out}, 32'hFB);
    check("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_idle("async_reset");
    step(1'b1);
    step(1'b0);
    check_idle("reset_strobe");
    rst = 1'b1;
    step(1'b0);
    check_idle("reset_release");
    send_word(vecs[4], 4);
    step(1'b0);
    check_idle("w4_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
